// File: rtl/null_decode_pkg.sv
// Shared opcode encodings, ALU op constants and FSM states for the null-class decode stage.
package null_decode_pkg;

    localparam logic [3:0] OP_UJMP  = 4'h0;
    localparam logic [3:0] OP_LDSW  = 4'h1;
    localparam logic [3:0] OP_DVGA  = 4'h2;
    localparam logic [3:0] OP_SWCL  = 4'h3;
    localparam logic [3:0] OP_RSV4  = 4'h4;
    localparam logic [3:0] OP_RSV5  = 4'h5;
    localparam logic [3:0] OP_RSV6  = 4'h6;
    localparam logic [3:0] OP_RSV7  = 4'h7;
    // Memops: bit2 = store, bit1 = stack, bit0 = offset.
    localparam logic [3:0] OP_RMEM  = 4'h8;
    localparam logic [3:0] OP_RMEMO = 4'h9;
    localparam logic [3:0] OP_RSTK  = 4'hA;
    localparam logic [3:0] OP_RSTKO = 4'hB;
    localparam logic [3:0] OP_WMEM  = 4'hC;
    localparam logic [3:0] OP_WMEMO = 4'hD;
    localparam logic [3:0] OP_WSTK  = 4'hE;
    localparam logic [3:0] OP_WSOF  = 4'hF;

    localparam logic [3:0] ALU_LEFT = 4'd0;
    localparam logic [3:0] ALU_IADD = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALID    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/null_field_decode.sv
// Combinational map from one null-class instruction (plus switch snapshot) to its control fields.
module null_field_decode
    import null_decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int PC_W   = 16
) (
    input  logic [4+2*REG_W-1:0] instruction,
    input  logic [DATA_W-1:0]    switches,
    output logic [3:0]           alu_op,
    output logic [REG_W-1:0]     a_sel,
    output logic [REG_W-1:0]     b_sel,
    output logic [REG_W-1:0]     out_sel,
    output logic                 a_source,
    output logic [DATA_W-1:0]    a_altern,
    output logic [1:0]           load_src,
    output logic                 store_mem,
    output logic                 store_stk,
    output logic                 pc_increment,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_target,
    output logic                 illegal,
    output logic                 is_memop
);

    localparam int INSTR_W = 4 + 2*REG_W;

    logic [3:0]       opcode;
    logic [REG_W-1:0] field_a;
    logic [REG_W-1:0] field_b;

    assign opcode  = instruction[INSTR_W-1 -: 4];
    assign field_a = instruction[2*REG_W-1:REG_W];
    assign field_b = instruction[REG_W-1:0];

    always_comb begin
        alu_op       = ALU_LEFT;
        a_sel        = '0;
        b_sel        = '0;
        out_sel      = '0;
        a_source     = 1'b0;
        a_altern     = '0;
        load_src     = 2'b00;
        store_mem    = 1'b0;
        store_stk    = 1'b0;
        pc_increment = 1'b1;
        pc_load      = 1'b0;
        pc_target    = '0;
        illegal      = 1'b0;
        is_memop     = 1'b0;
        case (opcode)
            OP_UJMP: begin
                pc_increment = 1'b0;
                pc_load      = 1'b1;
                pc_target    = PC_W'(instruction[2*REG_W-1:0]);
            end
            OP_LDSW: begin
                alu_op   = 4'(field_a);
                a_source = 1'b1;
                a_altern = switches;
                b_sel    = field_b;
                out_sel  = field_b;
                load_src = 2'b01;
            end
            OP_DVGA, OP_SWCL: ;
            OP_RSV4, OP_RSV5, OP_RSV6, OP_RSV7: illegal = 1'b1;
            OP_RMEM, OP_RMEMO, OP_RSTK, OP_RSTKO,
            OP_WMEM, OP_WMEMO, OP_WSTK, OP_WSOF: begin
                is_memop  = 1'b1;
                alu_op    = opcode[0] ? ALU_IADD : ALU_LEFT;
                a_sel     = field_a;
                b_sel     = field_b;
                out_sel   = opcode[2] ? field_a : field_b;
                load_src  = {~opcode[2], opcode[1] & ~opcode[2]};
                store_mem = opcode[2] & ~opcode[1];
                store_stk = opcode[2] & opcode[1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/null_decode_stage.sv
// Registered, handshaked null-class decode stage; holds the pipe while a memory/stack access is outstanding.
module null_decode_stage
    import null_decode_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int PC_W        = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4+2*REG_W-1:0] instruction,
    input  logic [DATA_W-1:0]    switches,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_op,
    output logic [REG_W-1:0]     a_sel,
    output logic [REG_W-1:0]     b_sel,
    output logic [REG_W-1:0]     out_sel,
    output logic                 a_source,
    output logic [DATA_W-1:0]    a_altern,
    output logic [1:0]           load_src,
    output logic                 store_mem,
    output logic                 store_stk,
    output logic                 pc_increment,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_target,
    output logic                 illegal,
    input  logic                 mem_done,
    output logic                 mem_timeout
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]        alu_op_d,   alu_op_q;
    logic [REG_W-1:0]  a_sel_d,    a_sel_q;
    logic [REG_W-1:0]  b_sel_d,    b_sel_q;
    logic [REG_W-1:0]  out_sel_d,  out_sel_q;
    logic              a_source_d, a_source_q;
    logic [DATA_W-1:0] a_altern_d, a_altern_q;
    logic [1:0]        load_src_d, load_src_q;
    logic              store_mem_d, store_mem_q;
    logic              store_stk_d, store_stk_q;
    logic              pc_inc_d,   pc_inc_q;
    logic              pc_load_d,  pc_load_q;
    logic [PC_W-1:0]   pc_tgt_d,   pc_tgt_q;
    logic              illegal_d,  illegal_q;
    logic              memop_d,    memop_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  cnt_q;
    state_e            state_q;
    logic              accept;

    null_field_decode #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .PC_W   (PC_W)
    ) u_field_decode (
        .instruction  (instruction),
        .switches     (switches),
        .alu_op       (alu_op_d),
        .a_sel        (a_sel_d),
        .b_sel        (b_sel_d),
        .out_sel      (out_sel_d),
        .a_source     (a_source_d),
        .a_altern     (a_altern_d),
        .load_src     (load_src_d),
        .store_mem    (store_mem_d),
        .store_stk    (store_stk_d),
        .pc_increment (pc_inc_d),
        .pc_load      (pc_load_d),
        .pc_target    (pc_tgt_d),
        .illegal      (illegal_d),
        .is_memop     (memop_d)
    );

    // A memop in VALID never frees the slot: it must pass through MEM_WAIT first.
    assign in_ready = ~rst & ((state_q == ST_IDLE) |
                              ((state_q == ST_VALID) & out_ready & ~memop_q));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            alu_op_q    <= '0;
            a_sel_q     <= '0;
            b_sel_q     <= '0;
            out_sel_q   <= '0;
            a_source_q  <= 1'b0;
            a_altern_q  <= '0;
            load_src_q  <= '0;
            store_mem_q <= 1'b0;
            store_stk_q <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_tgt_q    <= '0;
            illegal_q   <= 1'b0;
            memop_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_VALID;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (memop_q) begin
                            state_q <= ST_MEM_WAIT;
                            cnt_q   <= '0;
                        end else if (accept) begin
                            state_q <= ST_VALID;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    // Completion wins over a coincident timeout.
                    if (mem_done) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                alu_op_q    <= alu_op_d;
                a_sel_q     <= a_sel_d;
                b_sel_q     <= b_sel_d;
                out_sel_q   <= out_sel_d;
                a_source_q  <= a_source_d;
                a_altern_q  <= a_altern_d;
                load_src_q  <= load_src_d;
                store_mem_q <= store_mem_d;
                store_stk_q <= store_stk_d;
                pc_inc_q    <= pc_inc_d;
                pc_load_q   <= pc_load_d;
                pc_tgt_q    <= pc_tgt_d;
                illegal_q   <= illegal_d;
                memop_q     <= memop_d;
            end
        end
    end

    assign out_valid    = (state_q == ST_VALID);
    assign alu_op       = alu_op_q;
    assign a_sel        = a_sel_q;
    assign b_sel        = b_sel_q;
    assign out_sel      = out_sel_q;
    assign a_source     = a_source_q;
    assign a_altern     = a_altern_q;
    assign load_src     = load_src_q;
    assign store_mem    = store_mem_q;
    assign store_stk    = store_stk_q;
    assign pc_increment = pc_inc_q;
    assign pc_load      = pc_load_q;
    assign pc_target    = pc_tgt_q;
    assign illegal      = illegal_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_null_decode_stage.sv
// Directed-vector bench for null_decode_stage (REG_W=4, MEM_TIMEOUT=8).
module tb_null_decode_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int PC_W   = 16;
    localparam int MEM_TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       instruction;
    logic [DATA_W-1:0] switches;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_op;
    logic [REG_W-1:0]  a_sel, b_sel, out_sel;
    logic              a_source;
    logic [DATA_W-1:0] a_altern;
    logic [1:0]        load_src;
    logic              store_mem, store_stk, pc_increment, pc_load;
    logic [PC_W-1:0]   pc_target;
    logic              illegal;
    logic              mem_done;
    logic              mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    null_decode_stage #(
        .DATA_W      (DATA_W),
        .REG_W       (REG_W),
        .PC_W        (PC_W),
        .MEM_TIMEOUT (MEM_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .switches     (switches),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_op       (alu_op),
        .a_sel        (a_sel),
        .b_sel        (b_sel),
        .out_sel      (out_sel),
        .a_source     (a_source),
        .a_altern     (a_altern),
        .load_src     (load_src),
        .store_mem    (store_mem),
        .store_stk    (store_stk),
        .pc_increment (pc_increment),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .illegal      (illegal),
        .mem_done     (mem_done),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] ins, input logic [15:0] sw, input logic ordy);
        in_valid    = v;
        instruction = ins;
        switches    = sw;
        out_ready   = ordy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_done = 1'b0;
        drive(1'b0, 12'h000, 16'h0000, 1'b0);
        cyc(); cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_pc_inc", pc_increment, 0);
        rst = 1'b0; #1;
        chk("post_rst_in_ready", in_ready, 1);
        $display("txn reset done");

        // ldsw 0x1A3, switches BEEF
        drive(1'b1, 12'h1A3, 16'hBEEF, 1'b1);
        cyc();
        chk("ldsw_out_valid", out_valid, 1);
        chk("ldsw_alu_op", alu_op, 4'hA);
        chk("ldsw_a_source", a_source, 1);
        chk("ldsw_a_altern", a_altern, 16'hBEEF);
        chk("ldsw_out_sel", out_sel, 3);
        chk("ldsw_b_sel", b_sel, 3);
        chk("ldsw_load_src", load_src, 2'b01);
        chk("ldsw_pc_inc", pc_increment, 1);
        $display("txn ldsw 1A3");

        // ujmp accepted in the handshake cycle of ldsw
        drive(1'b1, 12'h05A, 16'h0000, 1'b1);
        chk("ujmp_in_ready", in_ready, 1);
        cyc();
        chk("ujmp_out_valid", out_valid, 1);
        chk("ujmp_pc_load", pc_load, 1);
        chk("ujmp_pc_inc", pc_increment, 0);
        chk("ujmp_pc_target", pc_target, 16'h005A);
        chk("ujmp_illegal", illegal, 0);
        chk("ujmp_load_src", load_src, 0);
        $display("txn ujmp 05A");

        drive(1'b1, 12'h1C5, 16'h1234, 1'b1);
        chk("b2b_in_ready", in_ready, 1);
        cyc();
        chk("b2b_alu_op", alu_op, 4'hC);
        chk("b2b_a_altern", a_altern, 16'h1234);
        chk("b2b_out_sel", out_sel, 5);
        chk("b2b_pc_load", pc_load, 0);
        $display("txn ldsw 1C5 back-to-back");

        drive(1'b0, 12'h000, 16'h0000, 1'b1);
        cyc();
        chk("idle_out_valid", out_valid, 0);

        // wsof 0xF27, mem_done 5 cycles after handshake
        drive(1'b1, 12'hF27, 16'h0000, 1'b1);
        cyc();
        chk("wsof_store_stk", store_stk, 1);
        chk("wsof_store_mem", store_mem, 0);
        chk("wsof_alu_op", alu_op, 1);
        chk("wsof_out_sel", out_sel, 2);
        chk("wsof_a_sel", a_sel, 2);
        chk("wsof_b_sel", b_sel, 7);
        chk("wsof_load_src", load_src, 2'b00);
        drive(1'b1, 12'h112, 16'h00FF, 1'b1);
        chk("wsof_valid_in_ready", in_ready, 0);
        cyc();
        chk("wsof_wait_out_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            chk("wsof_wait_in_ready", in_ready, 0);
            cyc();
        end
        mem_done = 1'b1; #1;
        chk("wsof_done_in_ready", in_ready, 0);
        cyc();
        mem_done = 1'b0; #1;
        chk("wsof_after_done_in_ready", in_ready, 1);
        $display("txn wsof F27");
        cyc();
        chk("post_wait_alu_op", alu_op, 1);
        chk("post_wait_a_altern", a_altern, 16'h00FF);
        chk("post_wait_timeout", mem_timeout, 0);
        $display("txn ldsw 112 after mem_done");

        // rmem 0x834 with out_ready low for 4 cycles
        drive(1'b1, 12'h834, 16'h0000, 1'b1);
        cyc();
        chk("rmem_alu_op", alu_op, 0);
        chk("rmem_out_sel", out_sel, 4);
        chk("rmem_load_src", load_src, 2'b10);
        drive(1'b1, 12'h1A3, 16'h5555, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_a_sel", a_sel, 3);
            chk("stall_out_sel", out_sel, 4);
            cyc();
        end
        drive(1'b0, 12'h000, 16'h0000, 1'b1);
        cyc();
        chk("stall_handshake_once", out_valid, 0);
        $display("txn rmem 834 stalled");

        // No mem_done: abort after 8 wait cycles
        for (int i = 0; i < MEM_TO - 1; i++) cyc();
        chk("to_pre_timeout", mem_timeout, 0);
        chk("to_pre_in_ready", in_ready, 0);
        cyc();
        chk("to_timeout", mem_timeout, 1);
        chk("to_in_ready", in_ready, 1);
        $display("txn rmem timeout");

        // Reserved opcode 0x5
        drive(1'b1, 12'h5AB, 16'h0000, 1'b1);
        cyc();
        chk("rsv_illegal", illegal, 1);
        chk("rsv_pc_inc", pc_increment, 1);
        chk("rsv_load_src", load_src, 0);
        chk("rsv_alu_op", alu_op, 0);
        chk("rsv_sticky_timeout", mem_timeout, 1);
        drive(1'b0, 12'h000, 16'h0000, 1'b1);
        cyc();
        $display("txn reserved 5AB");

        // Reset in the middle of MEM_WAIT
        drive(1'b1, 12'h812, 16'h0000, 1'b1);
        cyc();
        drive(1'b0, 12'h000, 16'h0000, 1'b1);
        cyc(); cyc(); cyc();
        rst = 1'b1; #1;
        chk("midrst_in_ready", in_ready, 0);
        cyc();
        rst = 1'b0; #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_timeout", mem_timeout, 0);
        chk("midrst_out_sel", out_sel, 0);
        chk("midrst_b_sel", b_sel, 0);
        chk("midrst_load_src", load_src, 0);
        chk("midrst_pc_inc", pc_increment, 0);
        chk("midrst_in_ready_after", in_ready, 1);
        mem_done = 1'b1;
        cyc();
        mem_done = 1'b0; #1;
        chk("late_done_out_valid", out_valid, 0);
        chk("late_done_in_ready", in_ready, 1);
        chk("late_done_timeout", mem_timeout, 0);
        $display("txn reset mid-wait");

        // mem_done coinciding with the abort cycle counts as completion
        drive(1'b1, 12'h834, 16'h0000, 1'b1);
        cyc();
        drive(1'b0, 12'h000, 16'h0000, 1'b1);
        cyc();
        for (int i = 0; i < MEM_TO - 1; i++) cyc();
        mem_done = 1'b1;
        cyc();
        mem_done = 1'b0; #1;
        chk("race_timeout", mem_timeout, 0);
        chk("race_in_ready", in_ready, 1);
        $display("txn mem_done at timeout");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
